reg_file_wb: RTL
================

# reg_file_wb

Register file with a one-stage write-back pipeline for the single-cycle/pipelined CPU datapath. It serves the operand-fetch stage: it accepts the two source register addresses and returns their 32-bit contents, which feed the ALU operand mux. It receives the execute-stage result and destination register, holds them for one cycle in a write-back register, then commits them to the array. Reads bypass the pending write, so a dependent instruction issued on the next cycle sees the new value.

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, register address width
- NUM_REGS, 32, register count (2**ADDR_W)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd_addr1  in  ADDR_W  source register 1 address
- rd_addr2  in  ADDR_W  source register 2 address
- rd_data1  out  DATA_W  contents of rd_addr1, combinational
- rd_data2  out  DATA_W  contents of rd_addr2, combinational
- ex_we  in  1  execute stage carries a valid register write this cycle
- ex_dest  in  ADDR_W  destination register of execute result
- ex_result  in  DATA_W  execute result
- stall  in  1  freeze write-back capture; pending entry holds
- wb_pend_valid  out  1  write-back register holds an uncommitted write
- wb_pend_addr  out  ADDR_W  destination of pending write (for hazard logic)
- commit_count  out  16  number of writes committed since reset, wraps

## Operation
- State: array regs[0..NUM_REGS-1]; pending entry {pend_valid, pend_addr, pend_data}; commit_count.
- Capture, each edge, when rst=0 and stall=0:
  - pend_valid <= ex_we && (ex_dest != 0); pend_addr <= ex_dest; pend_data <= ex_result.
- Capture when stall=1: pending entry holds, and ex_* inputs are ignored.
- Commit, each edge, when rst=0 and pend_valid=1 at the start of the cycle:
  - regs[pend_addr] <= pend_data; commit_count <= commit_count+1 (mod 2^16).
  - A commit happens even when stall=1. The held entry stays pend_valid=1 and re-commits the same value each stalled cycle; commit_count increments each time.
- Read port N, priority order:
  - addr==0 → 0;
  - pend_valid && addr==pend_addr → pend_data;
  - else regs[addr].
- Register 0 is never written. A write to r0 never sets pend_valid.
- Capture and commit on the same edge are independent. The new entry replaces the old one while the old one writes the array.
- Back-to-back writes to the same register: reads see the newest pending value, and the array ends with the newest value.

## Timing
- Read latency 0 cycles (combinational from rd_addr*, pending entry, array).
- Write path: ex inputs sampled at edge N. Visible through bypass after edge N. Resident in the array after edge N+1.
- Reset (rst=1 at an edge): all regs=0, pend_valid=0, pend_addr=0, pend_data=0, commit_count=0. Reset wins over capture and commit.
- Reset mid-operation discards any pending write; no commit occurs on that edge.
- rd_data1/rd_data2 = 0 for every address while state is in reset values.
- commit_count wraps 0xFFFF→0x0000 with no flag.

## Structure
- Shared CPU package holds DATA_W, ADDR_W, NUM_REGS, the REG_ZERO constant (0), and the write-back entry struct {valid, addr, data}.
- One sub-module is natural: wb_bypass_mux. It is purely combinational and implements the 3-way read priority. It is instantiated once per read port.
- The array and the pending register live in reg_file_wb.

## Test plan
- Reset: assert rst 1 cycle after random traffic → all reads return 0x00000000, wb_pend_valid=0, commit_count=0.
- Bypass then commit: ex_we=1, ex_dest=5, ex_result=0xDEADBEEF at edge N; rd_addr1=5.
  - After N: rd_data1=0xDEADBEEF and wb_pend_valid=1.
  - After N+1 with ex_we=0: still 0xDEADBEEF, wb_pend_valid=0, commit_count=1.
- r0 protection: ex_we=1, ex_dest=0, ex_result=0x12345678 → wb_pend_valid stays 0, rd_data1 for addr 0 = 0, commit_count unchanged.
- Back-to-back same dest: r7←0x11 at edge N, r7←0x22 at edge N+1.
  - After N+1: read r7=0x22.
  - After N+2: read r7=0x22, commit_count=2.
- Stall: r3←0xAA captured, then stall=1 for 3 cycles with ex_we=1, ex_dest=3, ex_result=0xBB.
  - r3 reads 0xAA throughout; wb_pend_addr=3.
  - commit_count increments each stalled cycle.
  - After stall drops, the next capture loads 0xBB.
- Reset mid-operation: capture r9←0x55 at edge N, rst=1 at edge N+1 → r9 reads 0, commit_count=0.

Source files
------------

// File: rtl/reg_file_wb_pkg.sv
// Shared CPU datapath definitions for the register file and its write-back stage.
package reg_file_wb_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    // Architectural zero register: reads as zero, never written.
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    // One pending write waiting to be committed to the array.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_file_wb_bypass_mux.sv
// Read-port priority select: r0 -> 0, then the pending write-back entry,
// then the array contents.
module wb_bypass_mux
    import reg_file_wb_pkg::*;
(
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_pend_valid,
    input  logic [ADDR_W-1:0] i_pend_addr,
    input  logic [DATA_W-1:0] i_pend_data,
    input  logic [DATA_W-1:0] i_arr_data,
    output logic [DATA_W-1:0] o_data
);

    // Zero register first, newest pending value second, array last.
    always_comb begin
        o_data = i_arr_data;
        if (i_addr == REG_ZERO) begin
            o_data = '0;
        end else if (i_pend_valid && (i_addr == i_pend_addr)) begin
            o_data = i_pend_data;
        end
    end

endmodule

// File: rtl/reg_file_wb.sv
// Register file with a one-stage write-back register and read bypass of the
// pending write. Port names match the existing datapath for drop-in use.
module reg_file_wb
    import reg_file_wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              ex_we,
    input  logic [ADDR_W-1:0] ex_dest,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              stall,
    output logic              wb_pend_valid,
    output logic [ADDR_W-1:0] wb_pend_addr,
    output logic [15:0]       commit_count
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    wb_entry_t         r_pend;
    logic [15:0]       r_commit_count;

    logic [DATA_W-1:0] w_arr1;
    logic [DATA_W-1:0] w_arr2;

    // Commit of the old entry and capture of the new one are independent on
    // the same edge; a stalled entry keeps re-committing its value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_pend         <= '0;
            r_commit_count <= '0;
        end else begin
            if (r_pend.valid) begin
                r_regs[r_pend.addr] <= r_pend.data;
                r_commit_count      <= r_commit_count + 16'd1;
            end
            if (!stall) begin
                r_pend.valid <= ex_we && (ex_dest != REG_ZERO);
                r_pend.addr  <= ex_dest;
                r_pend.data  <= ex_result;
            end
        end
    end

    assign w_arr1 = r_regs[rd_addr1];
    assign w_arr2 = r_regs[rd_addr2];

    wb_bypass_mux u_mux1 (
        .i_addr       (rd_addr1),
        .i_pend_valid (r_pend.valid),
        .i_pend_addr  (r_pend.addr),
        .i_pend_data  (r_pend.data),
        .i_arr_data   (w_arr1),
        .o_data       (rd_data1)
    );

    wb_bypass_mux u_mux2 (
        .i_addr       (rd_addr2),
        .i_pend_valid (r_pend.valid),
        .i_pend_addr  (r_pend.addr),
        .i_pend_data  (r_pend.data),
        .i_arr_data   (w_arr2),
        .o_data       (rd_data2)
    );

    assign wb_pend_valid = r_pend.valid;
    assign wb_pend_addr  = r_pend.addr;
    assign commit_count  = r_commit_count;

endmodule
